ball_seq_tx: RTL

Serial transmitter for the coloured-ball sequence line. The block drives the single-bit stream that the ball-sequence detector consumes.
- One "ball sequence" = three consecutive 1s (red, green, blue phases), followed by an inter-sequence gap of 0s.
- On request, the block emits a programmed number of sequences.
- It also drives a reference strobe marking the exact cycle a downstream detector must assert its detect output.

---
 rtl/ball_seq_tx_if.sv | 38 +++
 rtl/ball_seq_tx.sv | 128 ++++++++++++
 2 files changed

// File: rtl/ball_seq_tx_if.sv
// ball_seq_tx_if: request and stream signals of the ball-sequence transmitter.
//   start   request pulse, sampled only while the transmitter is idle
//   count   number of sequences to send, sampled with start
//   pause   stretches the inter-sequence gap, sampled on the last gap cycle
//   inj_err (ERR_INJECT_EN builds only) corrupt the first sequence of the run
//   di      serial ball stream
//   busy    run in progress
//   done    one-cycle completion pulse
//   exp_d   reference strobe: cycle in which a detector on di must assert d
//   sent    sequences fully emitted since the last accepted start
// master = requester side (drives start/count/pause), slave = transmitter.
interface ball_seq_tx_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic [CNT_W-1:0] count;
    logic             pause;
`ifdef ERR_INJECT_EN
    logic             inj_err;
`endif
    logic             di;
    logic             busy;
    logic             done;
    logic             exp_d;
    logic [CNT_W-1:0] sent;

`ifdef ERR_INJECT_EN
    modport master (output start, count, pause, inj_err,
                    input  di, busy, done, exp_d, sent);
    modport slave  (input  start, count, pause, inj_err,
                    output di, busy, done, exp_d, sent);
`else
    modport master (output start, count, pause,
                    input  di, busy, done, exp_d, sent);
    modport slave  (input  start, count, pause,
                    output di, busy, done, exp_d, sent);
`endif
endinterface

// File: rtl/ball_seq_tx.sv
// ball_seq_tx: serial transmitter for the coloured-ball sequence line.
// Each sequence is three 1s (red, green, blue) followed by GAP 0s before the
// next sequence; the gap can be stretched with pause. exp_d marks the blue
// cycle, where a downstream detector must fire.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  ball_seq_tx_if.slave (start/count/pause[/inj_err] in,
//        di/busy/done/exp_d/sent out, all outputs registered)
// Parameters: CNT_W width of count/sent, GAP gap length (1..15).
// Optional macro ERR_INJECT_EN adds inj_err: the first sequence of the run is
// sent as 1,0,1, without exp_d and without counting it in sent.
module ball_seq_tx #(
    parameter int CNT_W = 8,
    parameter int GAP   = 1
) (
    input logic           clk,
    input logic           rst,
    ball_seq_tx_if.slave  bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SR   = 3'd1;
    localparam logic [2:0] S_SG   = 3'd2;
    localparam logic [2:0] S_SB   = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;

    localparam logic [3:0] GAP_LOAD = 4'(GAP - 1);

    logic [2:0]       state;
    logic [CNT_W-1:0] remaining;
    logic [3:0]       gcnt;
    logic             di_q;
    logic             busy_q;
    logic             done_q;
    logic             exp_d_q;
    logic [CNT_W-1:0] sent_q;
`ifdef ERR_INJECT_EN
    logic             corrupt;  // sequence in flight is the injected 1,0,1
`else
    localparam logic  corrupt = 1'b0;
`endif

    // Outputs are computed from the next state and registered alongside it,
    // so di/exp_d line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            remaining <= '0;
            gcnt      <= '0;
            di_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            exp_d_q   <= 1'b0;
            sent_q    <= '0;
`ifdef ERR_INJECT_EN
            corrupt   <= 1'b0;
`endif
        end else begin
            done_q  <= 1'b0;
            exp_d_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    di_q <= 1'b0;
                    if (bus.start) begin
                        sent_q <= '0;
                        if (bus.count != '0) begin
                            remaining <= bus.count;
                            state     <= S_SR;
                            di_q      <= 1'b1;
                            busy_q    <= 1'b1;
`ifdef ERR_INJECT_EN
                            corrupt   <= bus.inj_err;
`endif
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                S_SR: begin
                    state <= S_SG;
                    di_q  <= ~corrupt;
                end
                S_SG: begin
                    state   <= S_SB;
                    di_q    <= 1'b1;
                    exp_d_q <= ~corrupt;
                end
                S_SB: begin
                    remaining <= remaining - CNT_W'(1);
                    if (!corrupt) begin
                        sent_q <= sent_q + CNT_W'(1);
                    end
`ifdef ERR_INJECT_EN
                    corrupt <= 1'b0;
`endif
                    di_q <= 1'b0;
                    if (remaining == CNT_W'(1)) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        state <= S_GAP;
                        gcnt  <= GAP_LOAD;
                    end
                end
                S_GAP: begin
                    if (gcnt != 4'd0) begin
                        gcnt <= gcnt - 4'd1;
                    end else if (!bus.pause) begin
                        state <= S_SR;
                        di_q  <= 1'b1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    di_q   <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.di    = di_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.exp_d = exp_d_q;
    assign bus.sent  = sent_q;
endmodule
